// File: rtl/fruit_spawn_scheduler.sv
// Fruit spawn scheduler: paces fruit launches across a pool of motion
// engines, picks the lowest free slot, and produces pseudo-random launch
// position and velocity from a free-running 16-bit LFSR. Difficulty level
// follows the cut count and shortens the spawn interval down to a floor.
module fruit_spawn_scheduler #(
  parameter int          N_SLOTS       = 4,
  parameter int          BASE_INTERVAL = 60,
  parameter int          INTERVAL_STEP = 3,
  parameter int          MIN_INTERVAL  = 15,
  parameter int          X_MIN         = 64,
  parameter int          VY_BASE       = 12,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic                      game_run,
  input  logic [7:0]                cut_count,
  input  logic [N_SLOTS-1:0]        slot_done,
  output logic [N_SLOTS-1:0]        new_fruit,
  output logic [9:0]                spawn_x,
  output logic signed [9:0]         spawn_vx,
  output logic signed [9:0]         spawn_vy,
  output logic [N_SLOTS-1:0]        active,
  output logic [3:0]                level
);

  // Wide enough for any interval the parameters can produce.
  localparam int TMR_W = $clog2(BASE_INTERVAL + MIN_INTERVAL + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_SEEK,
    S_FIRE
  } state_t;

  state_t                   r_state;
  logic [TMR_W-1:0]         r_timer;
  logic [15:0]              r_lfsr;
  logic [N_SLOTS-1:0]       r_active;
  logic [N_SLOTS-1:0]       r_new_fruit;
  logic [9:0]               r_spawn_x;
  logic signed [9:0]        r_spawn_vx;
  logic signed [9:0]        r_spawn_vy;

  logic                     w_lfsr_fb;
  logic [3:0]               w_level;
  logic [TMR_W-1:0]         w_interval;
  logic [N_SLOTS-1:0]       w_sel;
  logic                     w_any_free;
  logic [N_SLOTS-1:0]       w_active_kept;
  logic [9:0]               w_launch_x;
  logic signed [9:0]        w_launch_vx;
  logic signed [9:0]        w_launch_vy;

  // Level saturates at 15 once 75 fruits have been cut.
  function automatic logic [3:0] f_level(input logic [7:0] cuts);
    if (cuts >= 8'd75) return 4'd15;
    return 4'(cuts / 8'd5);
  endfunction

  // Interval shrinks by INTERVAL_STEP per level, clamped at MIN_INTERVAL.
  // The comparison is done before subtracting so it can never wrap.
  function automatic logic [TMR_W-1:0] f_interval(input logic [3:0] lvl);
    int dec;
    dec = int'(lvl) * INTERVAL_STEP;
    if (dec + MIN_INTERVAL >= BASE_INTERVAL) return TMR_W'(MIN_INTERVAL);
    return TMR_W'(BASE_INTERVAL - dec);
  endfunction

  // Launch X spans X_MIN .. X_MIN+511.
  function automatic logic [9:0] f_launch_x(input logic [8:0] pos_r);
    return 10'(X_MIN) + {1'b0, pos_r};
  endfunction

  // Horizontal speed 1..4, always pointing toward the screen centre.
  function automatic logic signed [9:0] f_launch_vx(input logic [9:0] x,
                                                    input logic [1:0] mag_r);
    logic signed [9:0] mag;
    mag = signed'({8'd0, mag_r}) + 10'sd1;
    return (x < 10'd320) ? mag : -mag;
  endfunction

  // Vertical speed is upward (negative), magnitude VY_BASE .. VY_BASE+7.
  function automatic logic signed [9:0] f_launch_vy(input logic [2:0] spd_r);
    logic signed [9:0] spd;
    spd = signed'(10'(VY_BASE)) + signed'({7'd0, spd_r});
    return -spd;
  endfunction

  assign w_lfsr_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_level       = f_level(cut_count);
  assign w_interval    = f_interval(w_level);
  assign w_active_kept = r_active & ~slot_done;
  assign w_launch_x    = f_launch_x(r_lfsr[8:0]);
  assign w_launch_vx   = f_launch_vx(w_launch_x, r_lfsr[10:9]);
  assign w_launch_vy   = f_launch_vy(r_lfsr[13:11]);

  // Lowest-index free slot, as a one-hot mask.
  always_comb begin
    w_sel      = '0;
    w_any_free = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!r_active[i] && !w_any_free) begin
        w_sel[i]   = 1'b1;
        w_any_free = 1'b1;
      end
    end
  end

  // Free-running LFSR; a nonzero seed keeps it out of the all-zero lock state.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  // Spawn FSM with slot occupancy, launch strobe and launch values.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_active    <= '0;
      r_new_fruit <= '0;
      r_spawn_x   <= '0;
      r_spawn_vx  <= '0;
      r_spawn_vy  <= '0;
    end else if (!game_run) begin
      // Halting gameplay aborts any pending spawn and empties the pool.
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_active    <= '0;
      r_new_fruit <= '0;
      r_spawn_x   <= '0;
      r_spawn_vx  <= '0;
      r_spawn_vy  <= '0;
    end else begin
      r_new_fruit <= '0;
      r_active    <= w_active_kept;
      case (r_state)
        S_IDLE: begin
          r_state <= S_COUNT;
          r_timer <= w_interval - TMR_W'(1);
        end
        S_COUNT: begin
          if (r_timer == '0) begin
            r_state <= S_SEEK;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        S_SEEK: begin
          // With every slot busy the spawn waits here rather than being lost.
          if (w_any_free) begin
            r_state     <= S_FIRE;
            r_new_fruit <= w_sel;
            // The new occupant wins over a same-edge done on that slot.
            r_active    <= w_active_kept | w_sel;
            r_spawn_x   <= w_launch_x;
            r_spawn_vx  <= w_launch_vx;
            r_spawn_vy  <= w_launch_vy;
          end
        end
        S_FIRE: begin
          r_state <= S_COUNT;
          r_timer <= w_interval - TMR_W'(1);
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign new_fruit = r_new_fruit;
  assign active    = r_active;
  assign spawn_x   = r_spawn_x;
  assign spawn_vx  = r_spawn_vx;
  assign spawn_vy  = r_spawn_vy;
  assign level     = w_level;

endmodule

// File: tb/tb_fruit_spawn_scheduler.sv
// Directed bench for fruit_spawn_scheduler: spawn timing, level cap,
// full-pool deferral, same-edge done/fire, run drop and reset replay.
module tb_fruit_spawn_scheduler;

  logic              frame_clk = 1'b0;
  logic              Reset;
  logic              game_run;
  logic [7:0]        cut_count;
  logic [3:0]        slot_done;
  logic [3:0]        new_fruit;
  logic [9:0]        spawn_x;
  logic signed [9:0] spawn_vx;
  logic signed [9:0] spawn_vy;
  logic [3:0]        active;
  logic [3:0]        level;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_lfsr;
  logic [15:0] m_prev;
  logic [9:0]  rec_x  [2];
  logic [9:0]  rec_vx [2];
  logic [9:0]  rec_vy [2];
  logic [9:0]  ex, evx, evy;

  fruit_spawn_scheduler dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .game_run  (game_run),
    .cut_count (cut_count),
    .slot_done (slot_done),
    .new_fruit (new_fruit),
    .spawn_x   (spawn_x),
    .spawn_vx  (spawn_vx),
    .spawn_vy  (spawn_vy),
    .active    (active),
    .level     (level)
  );

  always #5 frame_clk = ~frame_clk;

  // Reference LFSR; m_prev holds the value that was current before the last edge.
  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  function automatic void exp_launch(input logic [15:0] r, output logic [9:0] x,
                                     output logic [9:0] vx, output logic [9:0] vy);
    logic [9:0] m;
    x  = 10'd64 + {1'b0, r[8:0]};
    m  = 10'd1 + {8'd0, r[10:9]};
    vx = (x < 10'd320) ? m : (~m + 10'd1);
    vy = ~(10'd12 + {7'd0, r[13:11]}) + 10'd1;
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  // Counts edges until a strobe appears; returns bound+1 on timeout.
  task automatic wait_strobe(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (new_fruit == 4'b0000 && n <= bound);
  endtask

  task automatic apply_reset();
    Reset     = 1'b1;
    game_run  = 1'b0;
    cut_count = 8'd0;
    slot_done = 4'b0000;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (new_fruit !== 4'b0000) begin errors++; $display("FAIL reset_new_fruit: got %b want 0000", new_fruit); end
    checks++; if (active !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b want 0000", active); end
    checks++; if (spawn_x !== 10'd0) begin errors++; $display("FAIL reset_spawn_x: got %0d want 0", spawn_x); end
    checks++; if ({spawn_vx, spawn_vy} !== 20'd0) begin errors++; $display("FAIL reset_spawn_v: got vx=%0d vy=%0d want 0 0", spawn_vx, spawn_vy); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
  endtask

  task automatic test_first_spawns();
    int n;
    game_run  = 1'b1;
    cut_count = 8'd0;
    for (int s = 0; s < 2; s++) begin
      wait_strobe(200, n);
      checks++; if (n != 62) begin errors++; $display("FAIL first_spawn%0d_delay: got %0d edges want 62", s, n); end
      checks++; if (new_fruit !== (4'b0001 << s)) begin errors++; $display("FAIL first_spawn%0d_slot: got %b want %b", s, new_fruit, 4'b0001 << s); end
      checks++; if (active !== ((4'b0001 << (s + 1)) - 4'd1)) begin errors++; $display("FAIL first_spawn%0d_active: got %b", s, active); end
      exp_launch(m_prev, ex, evx, evy);
      checks++; if ({spawn_x, spawn_vx, spawn_vy} !== {ex, evx, evy}) begin errors++; $display("FAIL first_spawn%0d_launch: got x=%0d vx=%0d vy=%0d want x=%0d vx=%0d vy=%0d", s, spawn_x, spawn_vx, spawn_vy, ex, $signed(evx), $signed(evy)); end
      checks++; if (spawn_x < 10'd64 || spawn_x > 10'd575 || (spawn_vx[9] != (spawn_x >= 10'd320))) begin errors++; $display("FAIL first_spawn%0d_range: got x=%0d vx=%0d", s, spawn_x, spawn_vx); end
      rec_x[s]  = spawn_x;
      rec_vx[s] = spawn_vx;
      rec_vy[s] = spawn_vy;
    end
  endtask

  task automatic test_level_cap();
    int n;
    cut_count = 8'd75;
    #1;
    checks++; if (level !== 4'd15) begin errors++; $display("FAIL cap_level75: got %0d want 15", level); end
    wait_strobe(100, n);
    checks++; if (n != 17) begin errors++; $display("FAIL cap_period75: got %0d want 17", n); end
    checks++; if (new_fruit !== 4'b0100 || active !== 4'b0111) begin errors++; $display("FAIL cap_slot75: got nf=%b act=%b want 0100 0111", new_fruit, active); end
    cut_count = 8'd200;
    #1;
    checks++; if (level !== 4'd15) begin errors++; $display("FAIL cap_level200: got %0d want 15", level); end
    wait_strobe(100, n);
    checks++; if (n != 17) begin errors++; $display("FAIL cap_period200: got %0d want 17", n); end
    checks++; if (new_fruit !== 4'b1000 || active !== 4'b1111) begin errors++; $display("FAIL cap_slot200: got nf=%b act=%b want 1000 1111", new_fruit, active); end
    exp_launch(m_prev, ex, evx, evy);
  endtask

  task automatic test_full_park();
    int seen = 0;
    repeat (40) begin
      tick();
      if (new_fruit !== 4'b0000) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL park_no_strobe: got %0d strobes want 0", seen); end
    checks++; if (active !== 4'b1111) begin errors++; $display("FAIL park_active: got %b want 1111", active); end
    checks++; if ({spawn_x, spawn_vx, spawn_vy} !== {ex, evx, evy}) begin errors++; $display("FAIL park_launch_hold: got x=%0d vx=%0d vy=%0d want x=%0d", spawn_x, spawn_vx, spawn_vy, ex); end
    slot_done = 4'b0100;
    tick();
    slot_done = 4'b0000;
    checks++; if (active !== 4'b1011 || new_fruit !== 4'b0000) begin errors++; $display("FAIL park_clear: got act=%b nf=%b want 1011 0000", active, new_fruit); end
    tick();
    checks++; if (new_fruit !== 4'b0100 || active !== 4'b1111) begin errors++; $display("FAIL park_refire: got nf=%b act=%b want 0100 1111", new_fruit, active); end
    exp_launch(m_prev, ex, evx, evy);
    checks++; if ({spawn_x, spawn_vx, spawn_vy} !== {ex, evx, evy}) begin errors++; $display("FAIL park_launch: got x=%0d vx=%0d vy=%0d want x=%0d vx=%0d vy=%0d", spawn_x, spawn_vx, spawn_vy, ex, $signed(evx), $signed(evy)); end
  endtask

  task automatic test_same_edge();
    repeat (20) tick();
    slot_done = 4'b0010;
    tick();
    checks++; if (active !== 4'b1101 || new_fruit !== 4'b0000) begin errors++; $display("FAIL same_clear: got act=%b nf=%b want 1101 0000", active, new_fruit); end
    slot_done = 4'b0110;
    tick();
    checks++; if (new_fruit !== 4'b0010 || active !== 4'b1011) begin errors++; $display("FAIL same_edge_set_wins: got nf=%b act=%b want 0010 1011", new_fruit, active); end
    slot_done = 4'b0100;
    tick();
    slot_done = 4'b0000;
    checks++; if (active !== 4'b1011 || new_fruit !== 4'b0000) begin errors++; $display("FAIL idle_slot_done: got act=%b nf=%b want 1011 0000", active, new_fruit); end
  endtask

  task automatic test_run_drop();
    int n;
    int seen = 0;
    int cuts [8] = '{0, 4, 5, 9, 74, 75, 200, 255};
    int lv   [8] = '{0, 0, 1, 1, 14, 15, 15, 15};
    repeat (3) tick();
    checks++; if (active !== 4'b1011) begin errors++; $display("FAIL drop_pre_active: got %b want 1011", active); end
    game_run = 1'b0;
    tick();
    checks++; if (active !== 4'b0000 || new_fruit !== 4'b0000) begin errors++; $display("FAIL drop_clear: got act=%b nf=%b want 0000 0000", active, new_fruit); end
    checks++; if ({spawn_x, spawn_vx, spawn_vy} !== 30'd0) begin errors++; $display("FAIL drop_launch_zero: got x=%0d vx=%0d vy=%0d want 0", spawn_x, spawn_vx, spawn_vy); end
    for (int i = 0; i < 8; i++) begin
      cut_count = 8'(cuts[i]);
      #1;
      checks++; if (level !== 4'(lv[i])) begin errors++; $display("FAIL level_cut%0d: got %0d want %0d", cuts[i], level, lv[i]); end
    end
    repeat (10) begin
      tick();
      if (new_fruit !== 4'b0000) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL idle_quiet: got %0d strobes want 0", seen); end
    cut_count = 8'd10;
    #1;
    checks++; if (level !== 4'd2) begin errors++; $display("FAIL level_cut10: got %0d want 2", level); end
    game_run = 1'b1;
    wait_strobe(200, n);
    checks++; if (n != 56) begin errors++; $display("FAIL rerun_delay: got %0d edges want 56", n); end
    checks++; if (new_fruit !== 4'b0001 || active !== 4'b0001) begin errors++; $display("FAIL rerun_slot: got nf=%b act=%b want 0001 0001", new_fruit, active); end
    exp_launch(m_prev, ex, evx, evy);
    checks++; if ({spawn_x, spawn_vx, spawn_vy} !== {ex, evx, evy}) begin errors++; $display("FAIL rerun_launch: got x=%0d vx=%0d vy=%0d want x=%0d vx=%0d vy=%0d", spawn_x, spawn_vx, spawn_vy, ex, $signed(evx), $signed(evy)); end
  endtask

  task automatic test_reset_replay();
    int n;
    checks++; if (new_fruit !== 4'b0001) begin errors++; $display("FAIL replay_pre_fire: got %b want 0001", new_fruit); end
    Reset = 1'b1;
    #1;
    checks++; if (new_fruit !== 4'b0000 || active !== 4'b0000) begin errors++; $display("FAIL async_reset: got nf=%b act=%b want 0000 0000", new_fruit, active); end
    apply_reset();
    game_run  = 1'b1;
    cut_count = 8'd0;
    for (int s = 0; s < 2; s++) begin
      wait_strobe(200, n);
      checks++; if (n != 62) begin errors++; $display("FAIL replay%0d_delay: got %0d edges want 62", s, n); end
      checks++; if ({spawn_x, spawn_vx, spawn_vy} !== {rec_x[s], rec_vx[s], rec_vy[s]}) begin errors++; $display("FAIL replay%0d_launch: got x=%0d vx=%0d vy=%0d want x=%0d vx=%0d vy=%0d", s, spawn_x, spawn_vx, spawn_vy, rec_x[s], $signed(rec_vx[s]), $signed(rec_vy[s])); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    Reset     = 1'b1;
    game_run  = 1'b0;
    cut_count = 8'd0;
    slot_done = 4'b0000;
    test_reset();
    test_first_spawns();
    test_level_cap();
    test_full_park();
    test_same_edge();
    test_run_drop();
    test_reset_replay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
